// File: rtl/low_frequency_apb.sv
// Destination-side half of the APB async bridge: syncs the request toggle,
// runs one APB3/APB4 transfer and toggles b_ready_req back when it completes.
//
// Ports:
//   b_pclk, b_prst_n       b-domain clock, async active-low reset
//   a_apb_req              request toggle from the a-domain (async)
//   write/addr/wdata/      payload, held stable by the a-side while a
//   prot/strb              request is outstanding
//   b_ready_req            completion toggle to the a-domain
//   rdata                  registered read data for the a-domain
//   b_p*                   APB master bus (registered outputs)
module low_frequency_apb #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int STRB_WD = 4,
    parameter int PROT_WD = 3
) (
    input  logic               b_pclk,
    input  logic               b_prst_n,
    input  logic               a_apb_req,
    input  logic               write,
    input  logic [ADDR_WD-1:0] addr,
    input  logic [DATA_WD-1:0] wdata,
    input  logic [PROT_WD-1:0] prot,
    input  logic [STRB_WD-1:0] strb,
    output logic               b_ready_req,
    output logic [DATA_WD-1:0] rdata,
    output logic               b_psel,
    output logic               b_penable,
    output logic               b_pwrite,
    output logic [ADDR_WD-1:0] b_paddr,
    output logic [DATA_WD-1:0] b_pwdata,
    output logic [PROT_WD-1:0] b_pprot,
    output logic [STRB_WD-1:0] b_pstrb,
    input  logic [DATA_WD-1:0] b_prdata,
    input  logic               b_pready
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;
    logic   q1, q2, q3;
    logic   req_edge;
    logic   pending;

    // q1 may go metastable; q2/q3 are settled, so their difference marks
    // exactly one toggle of the a-side request.
    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= a_apb_req;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign req_edge = q2 ^ q3;

    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            b_psel      <= 1'b0;
            b_penable   <= 1'b0;
            b_pwrite    <= 1'b0;
            b_paddr     <= '0;
            b_pwdata    <= '0;
            b_pprot     <= '0;
            b_pstrb     <= '0;
            rdata       <= '0;
            b_ready_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_edge || pending) begin
                        b_pwrite <= write;
                        b_paddr  <= addr;
                        b_pwdata <= wdata;
                        b_pprot  <= prot;
                        b_pstrb  <= strb;
                        b_psel   <= 1'b1;
                        pending  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    // An early request is remembered once; extras are dropped.
                    if (req_edge) pending <= 1'b1;
                    b_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (req_edge) pending <= 1'b1;
                    if (b_pready) begin
                        b_psel    <= 1'b0;
                        b_penable <= 1'b0;
                        // rdata settles on the toggle edge; the a-side sees
                        // the toggle only after its own synchroniser.
                        if (!b_pwrite) rdata <= b_prdata;
                        b_ready_req <= ~b_ready_req;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_low_frequency_apb.sv
// Directed bench for low_frequency_apb: table of transfers plus hand-written
// sequences for early request and reset during ACCESS.
module tb_low_frequency_apb;

    logic        b_pclk;
    logic        b_prst_n;
    logic        a_apb_req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic        b_ready_req;
    logic [31:0] rdata;
    logic        b_psel;
    logic        b_penable;
    logic        b_pwrite;
    logic [31:0] b_paddr;
    logic [31:0] b_pwdata;
    logic [2:0]  b_pprot;
    logic [3:0]  b_pstrb;
    logic [31:0] b_prdata;
    logic        b_pready;

    low_frequency_apb dut (
        .b_pclk     (b_pclk),
        .b_prst_n   (b_prst_n),
        .a_apb_req  (a_apb_req),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .prot       (prot),
        .strb       (strb),
        .b_ready_req(b_ready_req),
        .rdata      (rdata),
        .b_psel     (b_psel),
        .b_penable  (b_penable),
        .b_pwrite   (b_pwrite),
        .b_paddr    (b_paddr),
        .b_pwdata   (b_pwdata),
        .b_pprot    (b_pprot),
        .b_pstrb    (b_pstrb),
        .b_prdata   (b_prdata),
        .b_pready   (b_pready)
    );

    initial begin
        b_pclk = 1'b0;
        forever #5 b_pclk = ~b_pclk;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];
    int   total = 0;
    int   bad = 0;
    logic exp_ready = 1'b0;

    task automatic tick();
        @(posedge b_pclk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic set_payload(input vec_t v);
        write = v.wr;
        addr  = v.addr;
        wdata = v.wdata;
        strb  = v.strb;
        prot  = v.prot;
    endtask

    // Toggle the request and follow the transfer edge by edge (E0..E4+waits).
    task automatic run_xfer(input vec_t v);
        set_payload(v);
        a_apb_req = ~a_apb_req;
        b_pready  = 1'b0;
        tick();
        tick();
        chk("lat_psel_e1", {63'd0, b_psel}, 64'd0);
        tick();
        chk("setup_sel_en", {62'd0, b_psel, b_penable}, 64'd2);
        chk("setup_addr", {32'd0, b_paddr}, {32'd0, v.addr});
        chk("setup_wdata", {32'd0, b_pwdata}, {32'd0, v.wdata});
        chk("setup_ctl", {56'd0, b_pwrite, b_pprot, b_pstrb},
            {56'd0, v.wr, v.prot, v.strb});
        tick();
        chk("access_sel_en", {62'd0, b_psel, b_penable}, 64'd3);
        for (int i = 0; i < v.waits; i++) begin
            tick();
            chk("wait_hold", {61'd0, b_psel, b_penable, b_ready_req},
                {61'd0, 2'b11, exp_ready});
        end
        b_pready = 1'b1;
        b_prdata = v.prdata;
        tick();
        exp_ready = ~exp_ready;
        chk("done_ready", {63'd0, b_ready_req}, {63'd0, exp_ready});
        chk("done_rdata", {32'd0, rdata}, {32'd0, v.exp_rdata});
        chk("done_idle", {62'd0, b_psel, b_penable}, 64'd0);
        b_pready = 1'b0;
        b_prdata = '0;
    endtask

    initial begin
        vec_t ev;
        vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0,
                    32'h1111_1111, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 3'b000, 3,
                    32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 3'b001, 1,
                    32'hFFFF_FFFF, 32'hA5A5_5A5A};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 3'b111, 0,
                    32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[4] = '{1'b1, 32'h0000_0008, 32'h0000_0001, 4'h1, 3'b000, 2,
                    32'h9999_9999, 32'h0BAD_F00D};

        b_prst_n  = 1'b0;
        a_apb_req = 1'b0;
        write     = 1'b0;
        addr      = '0;
        wdata     = '0;
        prot      = '0;
        strb      = '0;
        b_prdata  = 32'hFFFF_FFFF;
        b_pready  = 1'b1;

        // Reset held with request toggling and pready high: bus stays quiet.
        for (int i = 0; i < 4; i++) begin
            a_apb_req = ~a_apb_req;
            tick();
            chk("rst_ctl", {60'd0, b_psel, b_penable, b_pwrite, b_ready_req},
                64'd0);
            chk("rst_data", {32'd0, b_paddr | b_pwdata | rdata},
                {32'd0, 32'd0});
            chk("rst_prot_strb", {57'd0, b_pprot, b_pstrb}, 64'd0);
        end
        b_prst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_idle", {62'd0, b_psel, b_ready_req}, 64'd0);
        b_pready = 1'b0;

        foreach (vecs[k]) run_xfer(vecs[k]);
        chk("b2b_ready_final", {63'd0, b_ready_req}, 64'd1);

        // Early toggle during a waiting ACCESS is held and replayed.
        ev = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, 0,
               32'h0, 32'h0};
        set_payload(ev);
        a_apb_req = ~a_apb_req;
        repeat (3) tick();
        chk("early_setup", {62'd0, b_psel, b_penable}, 64'd2);
        write = 1'b1;
        addr  = 32'h0000_0044;
        wdata = 32'hCAFE_F00D;
        strb  = 4'hC;
        prot  = 3'b100;
        tick();
        chk("early_access", {62'd0, b_psel, b_penable}, 64'd3);
        a_apb_req = ~a_apb_req;
        repeat (4) tick();
        chk("early_wait", {61'd0, b_psel, b_penable, b_ready_req},
            {61'd0, 2'b11, exp_ready});
        chk("early_first_addr", {32'd0, b_paddr}, 64'h40);
        b_pready = 1'b1;
        b_prdata = 32'h5555_AAAA;
        tick();
        exp_ready = ~exp_ready;
        b_pready  = 1'b0;
        chk("early_done1", {62'd0, b_psel, b_ready_req}, {62'd0, 1'b0, exp_ready});
        chk("early_rdata1", {32'd0, rdata}, 64'h5555_AAAA);
        tick();
        chk("pend_setup", {62'd0, b_psel, b_penable}, 64'd2);
        chk("pend_addr", {32'd0, b_paddr}, 64'h44);
        chk("pend_wdata", {32'd0, b_pwdata}, 64'hCAFE_F00D);
        chk("pend_ctl", {56'd0, b_pwrite, b_pprot, b_pstrb},
            {56'd0, 1'b1, 3'b100, 4'hC});
        tick();
        chk("pend_access", {62'd0, b_psel, b_penable}, 64'd3);
        b_pready = 1'b1;
        tick();
        exp_ready = ~exp_ready;
        b_pready  = 1'b0;
        chk("pend_done", {62'd0, b_psel, b_ready_req}, {62'd0, 1'b0, exp_ready});
        chk("pend_rdata_kept", {32'd0, rdata}, 64'h5555_AAAA);
        repeat (5) tick();
        chk("no_third_xfer", {62'd0, b_psel, b_ready_req}, {62'd0, 1'b0, exp_ready});

        // Reset while in ACCESS abandons the bus immediately.
        ev = '{1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'b000, 0, 32'h0, 32'h0};
        set_payload(ev);
        a_apb_req = ~a_apb_req;
        repeat (4) tick();
        chk("mid_access", {61'd0, b_psel, b_penable, b_ready_req}, 64'd7);
        #2;
        b_prst_n  = 1'b0;
        a_apb_req = 1'b0;
        #1;
        chk("mid_rst_drop", {61'd0, b_psel, b_penable, b_ready_req}, 64'd0);
        chk("mid_rst_rdata", {32'd0, rdata}, 64'd0);
        repeat (2) tick();
        b_prst_n  = 1'b1;
        exp_ready = 1'b0;
        repeat (4) tick();
        chk("mid_rst_idle", {62'd0, b_psel, b_ready_req}, 64'd0);
        ev = '{1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b011, 1,
               32'h0000_0077, 32'h0000_0077};
        run_xfer(ev);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
